// File: rtl/mf_snap_pkg.sv
// Shared types and pointer helpers for the matched-filter snapshot controller.
package mf_snap_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_READ
  } mf_snap_state_t;

  localparam int DEPTH_LOG2_DEF = 9;
  localparam int DEPTH          = 1 << DEPTH_LOG2_DEF;

  // Buffer pointers are modulo 2**lg. Masking keeps the wrap explicit and
  // independent of the caller's pointer width.
  function automatic logic [31:0] ptr_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned lg);
    return (a + b) & ((32'd1 << lg) - 32'd1);
  endfunction

  function automatic logic [31:0] ptr_sub(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned lg);
    return (a - b) & ((32'd1 << lg) - 32'd1);
  endfunction

endpackage

// File: rtl/mf_snap_ram.sv
// Simple dual-port snapshot buffer: one write port, one registered read port.
module mf_snap_ram #(
  parameter int DW = 144,
  parameter int AW = 9
) (
  input  logic          aclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port.
  always_ff @(posedge aclk)
    if (we) mem[waddr] <= wdata;

  // Read port, one clock of latency.
  always_ff @(posedge aclk)
    if (re) rdata <= mem[raddr];

endmodule

// File: rtl/mf_snapshot_ctrl.sv
// Snapshot capture sequencer: registered channel mux into a circular buffer,
// pre/post-trigger window freeze, then skid-buffered stream readout.
module mf_snapshot_ctrl
  import mf_snap_pkg::*;
#(
  parameter int NBITS      = 18,
  parameter int NSAMPS     = 8,
  parameter int NCHAN      = 8,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                             aclk,
  input  logic                             rst,
  input  logic [NBITS*NSAMPS*NCHAN-1:0]    data_i,
  input  logic [$clog2(NCHAN)-1:0]         chan_sel_i,
  input  logic [DEPTH_LOG2-1:0]            pretrig_i,
  input  logic                             arm_i,
  input  logic                             trig_i,
  input  logic                             abort_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [NBITS*NSAMPS-1:0]          m_tdata,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic                             m_tlast
);

  localparam int DW = NBITS * NSAMPS;
  localparam int AW = DEPTH_LOG2;
  localparam int ND = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(ND - 1);
  localparam logic [AW:0]   LAST_CNT = (AW+1)'(ND - 1);

  mf_snap_state_t state_q, state_d;

  logic [$clog2(NCHAN)-1:0] chan_q, sel;
  logic [AW-1:0] pre_q, cnt_q, wr_ptr, rd_ptr;
  logic [AW:0]   rd_cnt;
  logic [DW-1:0] wr_word, rd_data;
  logic          we, issue, pop, push;
  logic          inflight_q, inflight_last_q;
  logic [DW-1:0] sk_data [2];
  logic [1:0]    sk_last;
  logic          sk_hd;
  logic [1:0]    sk_cnt, occ;

  // Until the arm is latched the mux follows chan_sel_i, so the word
  // registered in the arm cycle already comes from the requested channel.
  assign sel    = (state_q == S_IDLE) ? chan_sel_i : chan_q;
  assign we     = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign busy_o = (state_q != S_IDLE);

  assign m_tvalid = (sk_cnt != 2'd0);
  assign m_tdata  = sk_data[sk_hd];
  assign m_tlast  = m_tvalid && sk_last[sk_hd];
  assign pop      = m_tvalid && m_tready;
  assign push     = inflight_q;
  assign occ      = sk_cnt + {1'b0, inflight_q};

  // A read is only issued when the skid has room for it once it lands;
  // counting an accepting pop as room keeps back-to-back beats bubble-free.
  assign issue = (state_q == S_READ) && !abort_i && !rd_cnt[AW] && ((occ < 2'd2) || pop);

  // State register.
  always_ff @(posedge aclk)
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (arm_i)                 state_d = (pretrig_i == '0) ? S_WAIT : S_PRE;
      S_PRE:  if (cnt_q == pre_q - AW'(1)) state_d = S_WAIT;
      S_WAIT: if (trig_i)                state_d = (pre_q == LAST_IDX) ? S_READ : S_POST;
      S_POST: if (cnt_q == AW'(1))       state_d = S_READ;
      S_READ: if (pop && m_tlast)        state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  // Capture bookkeeping: mux register, write pointer, window counters.
  always_ff @(posedge aclk) begin
    if (rst) begin
      chan_q  <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_cnt  <= '0;
      wr_word <= '0;
    end else begin
      wr_word <= data_i[int'(sel)*DW +: DW];
      if (we)    wr_ptr <= AW'(ptr_add(32'(wr_ptr), 32'd1, AW));
      if (issue) begin
        rd_ptr <= AW'(ptr_add(32'(rd_ptr), 32'd1, AW));
        rd_cnt <= rd_cnt + (AW+1)'(1);
      end
      if (!abort_i) begin
        case (state_q)
          S_IDLE: if (arm_i) begin
            chan_q <= chan_sel_i;
            pre_q  <= pretrig_i;
            cnt_q  <= '0;
          end
          S_PRE:  cnt_q <= cnt_q + AW'(1);
          // The trigger beat lands at wr_ptr this cycle, so the window start
          // is known now and needs no separate trigger-address register.
          S_WAIT: if (trig_i) begin
            cnt_q  <= LAST_IDX - pre_q;
            rd_ptr <= AW'(ptr_sub(32'(wr_ptr), 32'(pre_q), AW));
            rd_cnt <= '0;
          end
          S_POST: cnt_q <= cnt_q - AW'(1);
          default: ;
        endcase
      end
    end
  end

  // Two-entry output skid fed by the one-cycle RAM read.
  always_ff @(posedge aclk) begin
    if (rst || abort_i) begin
      sk_cnt          <= '0;
      sk_hd           <= 1'b0;
      sk_last         <= '0;
      sk_data[0]      <= '0;
      sk_data[1]      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && (rd_cnt == LAST_CNT);
      if (push) begin
        sk_data[sk_hd ^ sk_cnt[0]] <= rd_data;
        sk_last[sk_hd ^ sk_cnt[0]] <= inflight_last_q;
      end
      if (pop) sk_hd <= ~sk_hd;
      case ({push, pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: ;
      endcase
    end
  end

  // Completion pulse follows the tlast handshake.
  always_ff @(posedge aclk)
    if (rst) done_o <= 1'b0;
    else     done_o <= pop && m_tlast && !abort_i;

  mf_snap_ram #(.DW(DW), .AW(AW)) u_ram (
    .aclk  (aclk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_mf_snapshot_ctrl.sv
// Bench for mf_snapshot_ctrl at DEPTH 16: table of capture windows plus
// hand sequences for abort and reset, checked against a beat scoreboard.
module tb_mf_snapshot_ctrl;

  localparam int NBITS = 18, NSAMPS = 8, NCHAN = 8, DL2 = 4, ND = 16;
  localparam int DW = NBITS * NSAMPS;

  logic                          aclk = 1'b0;
  logic                          rst  = 1'b1;
  logic [NBITS*NSAMPS*NCHAN-1:0] data_i;
  logic [2:0]                    chan_sel_i = '0;
  logic [DL2-1:0]                pretrig_i  = '0;
  logic                          arm_i = 1'b0, trig_i = 1'b0, abort_i = 1'b0, m_tready = 1'b1;
  logic                          busy_o, done_o, m_tvalid, m_tlast;
  logic [DW-1:0]                 m_tdata;

  always #5 aclk = ~aclk;

  mf_snapshot_ctrl #(.NBITS(NBITS), .NSAMPS(NSAMPS), .NCHAN(NCHAN), .DEPTH_LOG2(DL2)) dut (
    .aclk(aclk), .rst(rst), .data_i(data_i), .chan_sel_i(chan_sel_i), .pretrig_i(pretrig_i),
    .arm_i(arm_i), .trig_i(trig_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  typedef struct {
    int ch, pre, arm_cyc, tw;
    bit arm_trig, early, bp;
    int first, last;
  } vec_t;
  typedef struct { logic [DW-1:0] data; logic last; } beat_t;

  vec_t  tbl [6];
  beat_t exp_q [$];
  int    checks = 0, failures = 0, cyc = 0, popped = 0;
  bit    got_done = 0;
  bit    bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  function automatic logic [DW-1:0] rep(int v);
    logic [DW-1:0] r;
    for (int s = 0; s < NSAMPS; s++) r[s*NBITS +: NBITS] = NBITS'(v);
    return r;
  endfunction

  task automatic set_data();
    for (int c = 0; c < NCHAN; c++) data_i[c*DW +: DW] = rep(1000*c + cyc);
  endtask

  task automatic chk(string n, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic chk1(string n, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b", n, act, exp);
    end
  endtask

  task automatic fail(string n);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", n);
  endtask

  // One clock: score any handshake in the current cycle, advance, then check
  // hold-under-backpressure and the done pulse.
  task automatic step();
    bit            hs, dn, hold;
    logic [DW-1:0] held;
    beat_t         b;
    hs   = m_tvalid && m_tready;
    dn   = hs && m_tlast && !abort_i && !rst;
    hold = m_tvalid && !m_tready && !abort_i && !rst;
    held = m_tdata;
    if (hs) begin
      popped++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_beat actual=%0h expected=none", m_tdata);
      end else begin
        b = exp_q.pop_front();
        chk("m_tdata", m_tdata, b.data);
        chk1("m_tlast", m_tlast, b.last);
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
    set_data();
    if (hold) begin
      chk1("hold_valid", m_tvalid, 1'b1);
      chk("hold_data", m_tdata, held);
    end
    if (dn || done_o) chk1("done_o", done_o, dn);
    if (done_o) got_done = 1;
  endtask

  task automatic arm_and_trigger(vec_t v);
    int target, n;
    cyc = v.arm_cyc;
    set_data();
    chan_sel_i = 3'(v.ch);
    pretrig_i  = DL2'(v.pre);
    arm_i      = 1'b1;
    trig_i     = v.arm_trig;
    step();
    arm_i  = 1'b0;
    trig_i = 1'b0;
    chk1("busy_after_arm", busy_o, 1'b1);
    if (v.early) for (int i = 0; i < 3; i++) begin trig_i = 1'b1; step(); end
    trig_i = 1'b0;
    // The word written in a cycle is the previous cycle's data.
    target = v.tw - 1000*v.ch + 1;
    n = 0;
    while (cyc != target && n < 200) begin step(); n++; end
    if (cyc != target) fail("trig_align");
    for (int i = 0; i < ND; i++) exp_q.push_back('{rep(v.first + i), (i == ND-1)});
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
  endtask

  task automatic run_rec(vec_t v);
    int  lat;
    bit  seen;
    arm_and_trigger(v);
    lat = 0;
    seen = 0;
    got_done = 0;
    for (int n = 0; n < 300 && !got_done; n++) begin
      m_tready = v.bp ? bp_pat[n % 4] : 1'b1;
      step();
      lat++;
      if (m_tvalid && !seen) begin
        seen = 1;
        chk1("first_valid_latency", lat <= (ND - 1 - v.pre) + 2, 1'b1);
      end
    end
    m_tready = 1'b1;
    if (!got_done) fail("done_wait");
    chk1("busy_end", busy_o, 1'b0);
    chk("beats_left", DW'(exp_q.size()), '0);
  endtask

  initial begin
    int n;
    tbl[0] = '{2,  4,  40, 2050, 0, 0, 0, 2046, 2061};  // basic window
    tbl[1] = '{0,  0,  28,   30, 1, 0, 0,   30,   45};  // pretrig 0, trig in arm cycle
    tbl[2] = '{1, 15,  85, 1100, 0, 0, 0, 1085, 1100};  // pretrig 15, no post
    tbl[3] = '{2,  4,  40, 2050, 0, 0, 1, 2046, 2061};  // backpressure
    tbl[4] = '{3,  6, 100, 3149, 0, 1, 0, 3143, 3158};  // early trig, wrap
    tbl[5] = '{6,  3, 400, 6410, 0, 0, 0, 6407, 6422};  // re-arm after abort/reset

    set_data();
    repeat (3) step();
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_tvalid", m_tvalid, 1'b0);
    chk1("rst_tlast", m_tlast, 1'b0);
    chk("rst_tdata", m_tdata, '0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_rec(tbl[i]);
      repeat (2) step();
    end

    // Abort while beat 5 is on the bus.
    popped = 0;
    arm_and_trigger('{5, 4, 200, 5210, 0, 0, 0, 5206, 5221});
    n = 0;
    while (!abort_i && n < 100) begin
      if (m_tvalid && popped == 5) abort_i = 1'b1;
      step();
      n++;
    end
    if (!abort_i) fail("abort_reach");
    abort_i = 1'b0;
    chk1("abort_tvalid", m_tvalid, 1'b0);
    chk1("abort_busy", busy_o, 1'b0);
    repeat (4) begin step(); chk1("abort_no_done", done_o, 1'b0); end
    exp_q.delete();
    run_rec(tbl[5]);
    repeat (2) step();

    // Reset while in POST.
    arm_and_trigger('{4, 2, 300, 4305, 0, 0, 0, 4303, 4318});
    chk1("post_busy", busy_o, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rst_post_tvalid", m_tvalid, 1'b0);
    chk1("rst_post_busy", busy_o, 1'b0);
    repeat (4) begin step(); chk1("rst_no_done", done_o, 1'b0); end
    exp_q.delete();
    run_rec(tbl[5]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
